// File: rtl/keccak_pkg.sv
// Shared Keccak constants and chi-stage FSM encodings.
// CHI_STAGE_OUT_REG_EN adds the OREG state used by the registered-output build.
package keccak_pkg;

    localparam int SLICE_W = 25;
    localparam int N_LINES = 64;
    localparam int LINE_W  = 6;
    localparam int ROW_W   = 5;
    localparam int N_ROWS  = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_LATCH = 3'd3,
        ST_WRITE = 3'd4,
`ifdef CHI_STAGE_OUT_REG_EN
        ST_DONE  = 3'd5,
        ST_OREG  = 3'd6
`else
        ST_DONE  = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/chi_stage_if.sv
// Slice-file bus between chi_stage (master) and the state-file/controller side (slave).
interface chi_stage_if #(
    parameter int SLICE_W = keccak_pkg::SLICE_W,
    parameter int LINE_W  = keccak_pkg::LINE_W
);
    logic               start;
    logic               read_file;
    logic [SLICE_W-1:0] slice_in;
    logic [LINE_W-1:0]  line_index;
    logic               write_file;
    logic [SLICE_W-1:0] slice_out;
    logic               busy;
    logic               finish;

    modport master (
        input  start, slice_in,
        output read_file, line_index, write_file, slice_out, busy, finish
    );

    modport slave (
        output start, slice_in,
        input  read_file, line_index, write_file, slice_out, busy, finish
    );
endinterface

// File: rtl/chi_row.sv
// Combinational chi transform of one 5-lane row: out[x] = in[x] ^ (~in[x+1] & in[x+2]).
module chi_row
    import keccak_pkg::*;
(
    input  logic [ROW_W-1:0] row_in,
    output logic [ROW_W-1:0] row_out
);

    for (genvar gi = 0; gi < ROW_W; gi++) begin : g_lane
        assign row_out[gi] = row_in[gi] ^ (~row_in[(gi + 1) % ROW_W] & row_in[(gi + 2) % ROW_W]);
    end

endmodule

// File: rtl/chi_stage.sv
// Chi step over a full state, one slice at a time: read, latch, transform, write back.
// Define CHI_STAGE_OUT_REG_EN to register the chi result (OREG state, 4 cycles/slice).
module chi_stage #(
    parameter int SLICE_W = keccak_pkg::SLICE_W,
    parameter int N_LINES = keccak_pkg::N_LINES
) (
    input  logic       clk,
    input  logic       rst,
    chi_stage_if.master bus
);
    import keccak_pkg::*;

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(N_LINES - 1);

    state_t             state_reg, state_next;
    logic [LINE_W-1:0]  cnt_reg;
    logic [SLICE_W-1:0] slice_reg;
    logic [SLICE_W-1:0] chi_result;
    logic               read_next, write_next, busy_next, finish_next;

    for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row
        chi_row u_row (
            .row_in  (slice_reg[ROW_W*gi +: ROW_W]),
            .row_out (chi_result[ROW_W*gi +: ROW_W])
        );
    end

`ifdef CHI_STAGE_OUT_REG_EN
    logic [SLICE_W-1:0] out_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else if (state_reg == ST_OREG) begin
            out_reg <= chi_result;
        end
    end

    assign bus.slice_out = out_reg;
`else
    // slice_reg only changes in LATCH, so this holds the last result between writes.
    assign bus.slice_out = chi_result;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            slice_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                cnt_reg <= '0;
            end else if (state_reg == ST_WRITE) begin
                cnt_reg <= cnt_reg + LINE_W'(1);
            end
            if (state_reg == ST_LATCH) begin
                slice_reg <= bus.slice_in;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        read_next   = 1'b0;
        write_next  = 1'b0;
        busy_next   = 1'b1;
        finish_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (bus.start) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT:  state_next = ST_READ;
            ST_READ: begin
                read_next  = 1'b1;
                state_next = ST_LATCH;
            end
`ifdef CHI_STAGE_OUT_REG_EN
            ST_LATCH: state_next = ST_OREG;
            ST_OREG:  state_next = ST_WRITE;
`else
            ST_LATCH: state_next = ST_WRITE;
`endif
            ST_WRITE: begin
                write_next = 1'b1;
                state_next = (cnt_reg == LAST_LINE) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                finish_next = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.read_file  = read_next;
    assign bus.write_file = write_next;
    assign bus.busy       = busy_next;
    assign bus.finish     = finish_next;
    assign bus.line_index = cnt_reg;

endmodule
